fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of Eka: owns the PC and issues word fetches to instruction memory over a
//  valid/ready request port plus a valid response port. Buffers the returned word and presents it
//  (with its PC) to the decoder's ip_inst input under a valid/ready handshake.
//  Accepts branch/jump redirects from execute and discards any fetch in flight when one arrives.
//  Outputs a NOP (addi x0,x0,0) whenever no valid instruction is held.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC of the first fetch after reset; bits [1:0] must be 0
//  NOP_INST   32'h0000_0013   word driven on inst_out while inst_valid=0
// PORTS
//  clk              in   1   core clock; all state updates on rising edge
//  reset            in   1   synchronous, active-high reset
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   imem accepts request this cycle
//  imem_req_addr    out  32  byte address of fetch (word aligned)
//  imem_resp_valid  in   1   response word valid; one response per accepted request, in order
//  imem_resp_data   in   32  fetched instruction word
//  inst_valid       out  1   inst_out/inst_pc hold a live instruction
//  inst_ready       in   1   decoder/core consumes instruction this cycle
//  inst_out         out  32  instruction to decoder ip_inst
//  inst_pc          out  32  PC of inst_out
//  redirect_valid   in   1   taken branch / JAL: restart fetch at redirect_pc
//  redirect_pc      in   32  target; bits [1:0] ignored (forced to 0)
//  fetch_count      out  32  instructions delivered (inst_valid & inst_ready), wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (sync, reset=1 at edge): state=IDLE, pc=RESET_PC, drop=0, imem_req_valid=0,
//   inst_valid=0, inst_out=NOP_INST, inst_pc=RESET_PC, fetch_count=0. Reset mid-fetch abandons the
//   request; a response arriving after reset and before a new request is accepted is ignored.
//  All outputs are registered or decoded from state only; no input->output combinational path.
//  imem_req_addr = pc at all times; imem_req_valid = (state==REQ).
//  States:
//   IDLE : entered only by reset; -> REQ on the next cycle.
//   REQ  : request asserted. req_ready=1 -> WAIT. Redirect: pc<=redirect_pc; if req_ready the same
//          cycle, the accepted (old) fetch is marked drop=1 and state -> WAIT; otherwise stay in REQ
//          (a request may be retargeted before acceptance).
//   WAIT : await response. resp_valid & drop -> discard word, drop<=0, -> REQ.
//          resp_valid & !drop & !redirect -> inst_out<=resp_data, inst_pc<=pc, inst_valid<=1, -> HOLD.
//          Redirect: pc<=redirect_pc, drop<=1; if resp_valid same cycle, discard the word,
//          drop<=0, -> REQ.
//   HOLD : inst_valid=1, inst_out stable until consumed.
//          inst_ready & !redirect -> pc<=pc+4, inst_valid<=0, inst_out<=NOP_INST, -> REQ.
//          Redirect (with or without inst_ready) -> pc<=redirect_pc, inst_valid<=0,
//          inst_out<=NOP_INST, -> REQ; the held instruction counts as consumed only if inst_ready=1.
//  Latency: req accepted in cycle N, resp in cycle M>N -> inst_valid=1 in M+1. Back-to-back,
//   zero-wait imem with inst_ready=1 delivers one instruction every 3 cycles (REQ, WAIT, HOLD).
//  pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
//  fetch_count increments by 1 in every cycle with inst_valid & inst_ready (including redirect cycles).
//  resp_valid outside WAIT: ignored (protocol error, no state change).
// TESTING
//  1 Reset, zero-wait imem returning {0x00500093, 0x00A00113} -> inst_pc 0x0 then 0x4; inst_out
//    matches each word; fetch_count=2; imem_req_addr sequence 0x0, 0x4, 0x8.
//  2 inst_ready=0 for 5 cycles in HOLD -> inst_out/inst_pc stable, imem_req_valid=0, no new request.
//  3 Redirect to 0x100 in WAIT, resp 0xDEADBEEF arrives 2 cycles later -> word dropped,
//    next request addr 0x100, inst_valid never high with 0xDEADBEEF.
//  4 Redirect to 0x203 in HOLD with inst_ready=1 -> fetch_count+1, next req addr 0x200, inst_out=NOP.
//  5 imem_req_ready low for 4 cycles, redirect to 0x40 in 2nd cycle -> accepted addr 0x40, drop=0.
//  6 Assert reset while in WAIT, resp arrives during reset -> all reset values; first req addr RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: Eka instruction fetch stage; owns the PC, fetches words from imem, hands them to decode.
// Ports:
//   clk, reset                        clock and synchronous active-high reset
//   imem_req_valid/ready/addr         fetch request port (addr = pc, word aligned)
//   imem_resp_valid/data              in-order response port, one word per accepted request
//   inst_valid/ready, inst_out/pc     instruction to decoder; inst_out is NOP_INST when not valid
//   redirect_valid, redirect_pc       restart fetch at redirect_pc (low two bits cleared)
//   fetch_count                       instructions consumed by the decoder, wrapping
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, inst_out_n, inst_pc_n, target;
  logic drop, drop_n;
  assign target = redirect_pc & ~32'h3;
  assign imem_req_addr = pc;
  assign imem_req_valid = state == REQ;
  assign inst_valid = state == HOLD;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      drop <= 1'b0;
      inst_out <= NOP_INST;
      inst_pc <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drop <= drop_n;
      inst_out <= inst_out_n;
      inst_pc <= inst_pc_n;
      fetch_count <= fetch_count + {31'd0, inst_valid & inst_ready};
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    drop_n = drop;
    inst_out_n = inst_out;
    inst_pc_n = inst_pc;
    case (state)
      REQ: begin
        pc_n = redirect_valid ? target : pc;
        // a fetch accepted together with a redirect is for the old pc and must be discarded
        if (imem_req_ready) begin
          state_n = WAIT;
          drop_n = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (drop || redirect_valid) begin
            drop_n = 1'b0;
            pc_n = redirect_valid ? target : pc;
            state_n = REQ;
          end else begin
            inst_out_n = imem_resp_data;
            inst_pc_n = pc;
            state_n = HOLD;
          end
        end else if (redirect_valid) begin
          pc_n = target;
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || inst_ready) begin
          pc_n = redirect_valid ? target : pc + 32'd4;
          inst_out_n = NOP_INST;
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end
endmodule
